// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Arbitrates the IF-stage fetch port and the MEM-stage data port onto two
//   asynchronous SRAM banks (BASE, EXT). Each bank runs its own access FSM
//   and generates low-active CE/OE/WE/BE timing. Read data is returned to the
//   owning requester with a one-cycle VALID pulse; MEM wins bank conflicts.
//
// Ports
//   CLK, RST                 clock, asynchronous active-low reset
//   IF_REQ/SEL/ADDR          fetch request (always a read)
//   IF_RDATA/IF_VALID        fetch completion
//   MEM_REQ/WE/BE_N/SEL/ADDR/WDATA   data request
//   MEM_RDATA/MEM_VALID      data completion
//   STALL_IF, STALL_MEM      pipeline stalls (REQ & ~VALID)
//   BASE_* / EXT_*           SRAM pins per bank (strobes low-active,
//                            DRIVE=1 enables the write-data pad driver)
// ---------------------------------------------------------------------------

// One bank access sequencer. Latches the granted request and plays out the
// read or write strobe sequence; o_done marks the last cycle of an access.
module sram_arbiter_bank #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int RD_CYCLES = 1,
  parameter int WR_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_grant,
  input  logic              i_grantWe,
  input  logic              i_grantMem,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_beN,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_idle,
  output logic              o_done,
  output logic              o_doneRead,
  output logic              o_ownerMem,
  output logic              o_ceN,
  output logic              o_oeN,
  output logic              o_weN,
  output logic [3:0]        o_beN,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_drive
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WSETUP = 3'd2,
    WPULSE = 3'd3,
    WHOLD  = 3'd4
  } bank_state_t;

  localparam logic [1:0] RD_LAST = 2'(RD_CYCLES - 1);
  localparam logic [1:0] WR_LAST = 2'(WR_CYCLES - 1);

  bank_state_t       r_state;
  bank_state_t       w_stateNext;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_beN;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ownerMem;

  // State register, in-state counter and request latch. The counter restarts
  // at zero on every state change so each state times itself independently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 2'd0;
      r_addr     <= '0;
      r_beN      <= 4'hF;
      r_wdata    <= '0;
      r_ownerMem <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_stateNext != r_state) r_cnt <= 2'd0;
      else if (r_state != IDLE)   r_cnt <= r_cnt + 2'd1;
      if (r_state == IDLE && i_grant) begin
        r_addr     <= i_addr;
        r_beN      <= i_beN;
        r_wdata    <= i_wdata;
        r_ownerMem <= i_grantMem;
      end
    end
  end

  // Next-state and pin decode.
  always_comb begin
    w_stateNext = r_state;
    o_ceN       = 1'b1;
    o_oeN       = 1'b1;
    o_weN       = 1'b1;
    o_beN       = 4'hF;
    o_drive     = 1'b0;
    o_done      = 1'b0;
    o_doneRead  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_grant) w_stateNext = i_grantWe ? WSETUP : READ;
      end
      READ: begin
        o_ceN      = 1'b0;
        o_oeN      = 1'b0;
        o_beN      = r_beN;
        o_doneRead = 1'b1;
        if (r_cnt == RD_LAST) begin
          w_stateNext = IDLE;
          o_done      = 1'b1;
        end
      end
      WSETUP: begin
        o_ceN       = 1'b0;
        o_beN       = r_beN;
        o_drive     = 1'b1;
        w_stateNext = WPULSE;
      end
      WPULSE: begin
        o_ceN   = 1'b0;
        o_weN   = 1'b0;
        o_beN   = r_beN;
        o_drive = 1'b1;
        if (r_cnt == WR_LAST) w_stateNext = WHOLD;
      end
      WHOLD: begin
        o_ceN       = 1'b0;
        o_beN       = r_beN;
        o_drive     = 1'b1;
        o_done      = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign o_idle     = (r_state == IDLE);
  assign o_ownerMem = r_ownerMem;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;

endmodule

module sram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int RD_CYCLES = 1,
  parameter int WR_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [1:0]        IF_SEL,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic [DATA_W-1:0] IF_RDATA,
  output logic              IF_VALID,
  input  logic              MEM_REQ,
  input  logic              MEM_WE,
  input  logic [3:0]        MEM_BE_N,
  input  logic [1:0]        MEM_SEL,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_WDATA,
  output logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_VALID,
  output logic              STALL_IF,
  output logic              STALL_MEM,
  output logic              BASE_CE_N,
  output logic              BASE_OE_N,
  output logic              BASE_WE_N,
  output logic [3:0]        BASE_BE_N,
  output logic [ADDR_W-1:0] BASE_ADDR,
  output logic [DATA_W-1:0] BASE_WDATA,
  output logic              BASE_DRIVE,
  input  logic [DATA_W-1:0] BASE_RDATA,
  output logic              EXT_CE_N,
  output logic              EXT_OE_N,
  output logic              EXT_WE_N,
  output logic [3:0]        EXT_BE_N,
  output logic [ADDR_W-1:0] EXT_ADDR,
  output logic [DATA_W-1:0] EXT_WDATA,
  output logic              EXT_DRIVE,
  input  logic [DATA_W-1:0] EXT_RDATA
);

  logic              r_ifPend, r_memPend;
  logic              r_ifValid, r_memValid;
  logic [DATA_W-1:0] r_ifRdata, r_memRdata;

  logic w_ifElig, w_memElig;
  logic w_ifToBase, w_ifToExt, w_ifNone;
  logic w_memToBase, w_memToExt, w_memNone;
  logic w_baseIdle, w_extIdle;
  logic w_baseGrantMem, w_baseGrantIf, w_extGrantMem, w_extGrantIf;
  logic w_ifNoneGrant, w_memNoneGrant, w_ifGrant, w_memGrant;
  logic w_baseDone, w_baseDoneRead, w_baseOwnerMem;
  logic w_extDone, w_extDoneRead, w_extOwnerMem;

  // Select decode: bit0 low picks BASE even when both bits are low;
  // both bits high addresses no bank at all.
  assign w_ifToBase  = ~IF_SEL[0];
  assign w_ifToExt   = (IF_SEL == 2'b01);
  assign w_ifNone    = (IF_SEL == 2'b11);
  assign w_memToBase = ~MEM_SEL[0];
  assign w_memToExt  = (MEM_SEL == 2'b01);
  assign w_memNone   = (MEM_SEL == 2'b11);

  // Excluding the VALID cycle keeps a still-asserted REQ from being granted
  // a second time while its completion is on the outputs.
  assign w_ifElig  = IF_REQ  & ~r_ifPend  & ~r_ifValid;
  assign w_memElig = MEM_REQ & ~r_memPend & ~r_memValid;

  // MEM takes the bank whenever both want it; IF waits for a later idle cycle.
  assign w_baseGrantMem = w_baseIdle & w_memElig & w_memToBase;
  assign w_baseGrantIf  = w_baseIdle & w_ifElig & w_ifToBase & ~(w_memElig & w_memToBase);
  assign w_extGrantMem  = w_extIdle & w_memElig & w_memToExt;
  assign w_extGrantIf   = w_extIdle & w_ifElig & w_ifToExt & ~(w_memElig & w_memToExt);
  assign w_ifNoneGrant  = w_ifElig & w_ifNone;
  assign w_memNoneGrant = w_memElig & w_memNone;
  assign w_ifGrant      = w_baseGrantIf | w_extGrantIf | w_ifNoneGrant;
  assign w_memGrant     = w_baseGrantMem | w_extGrantMem | w_memNoneGrant;

  sram_arbiter_bank #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)
  ) u_base (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_grant    (w_baseGrantMem | w_baseGrantIf),
    .i_grantWe  (w_baseGrantMem & MEM_WE),
    .i_grantMem (w_baseGrantMem),
    .i_addr     (w_baseGrantMem ? MEM_ADDR : IF_ADDR),
    .i_beN      (w_baseGrantMem ? MEM_BE_N : 4'h0),
    .i_wdata    (MEM_WDATA),
    .o_idle     (w_baseIdle),
    .o_done     (w_baseDone),
    .o_doneRead (w_baseDoneRead),
    .o_ownerMem (w_baseOwnerMem),
    .o_ceN      (BASE_CE_N),
    .o_oeN      (BASE_OE_N),
    .o_weN      (BASE_WE_N),
    .o_beN      (BASE_BE_N),
    .o_addr     (BASE_ADDR),
    .o_wdata    (BASE_WDATA),
    .o_drive    (BASE_DRIVE)
  );

  sram_arbiter_bank #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)
  ) u_ext (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_grant    (w_extGrantMem | w_extGrantIf),
    .i_grantWe  (w_extGrantMem & MEM_WE),
    .i_grantMem (w_extGrantMem),
    .i_addr     (w_extGrantMem ? MEM_ADDR : IF_ADDR),
    .i_beN      (w_extGrantMem ? MEM_BE_N : 4'h0),
    .i_wdata    (MEM_WDATA),
    .o_idle     (w_extIdle),
    .o_done     (w_extDone),
    .o_doneRead (w_extDoneRead),
    .o_ownerMem (w_extOwnerMem),
    .o_ceN      (EXT_CE_N),
    .o_oeN      (EXT_OE_N),
    .o_weN      (EXT_WE_N),
    .o_beN      (EXT_BE_N),
    .o_addr     (EXT_ADDR),
    .o_wdata    (EXT_WDATA),
    .o_drive    (EXT_DRIVE)
  );

  // Completion: VALID is registered from the bank's last access cycle (or
  // from the grant itself for an unmapped select), so it lands in the first
  // idle cycle. Read data is captured on that same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ifPend   <= 1'b0;
      r_memPend  <= 1'b0;
      r_ifValid  <= 1'b0;
      r_memValid <= 1'b0;
      r_ifRdata  <= '0;
      r_memRdata <= '0;
    end else begin
      if (w_ifGrant)      r_ifPend <= 1'b1;
      else if (r_ifValid) r_ifPend <= 1'b0;
      if (w_memGrant)      r_memPend <= 1'b1;
      else if (r_memValid) r_memPend <= 1'b0;

      r_ifValid  <= w_ifNoneGrant | (w_baseDone & ~w_baseOwnerMem) |
                    (w_extDone & ~w_extOwnerMem);
      r_memValid <= w_memNoneGrant | (w_baseDone & w_baseOwnerMem) |
                    (w_extDone & w_extOwnerMem);

      if (w_ifNoneGrant)
        r_ifRdata <= '0;
      else if (w_baseDone & w_baseDoneRead & ~w_baseOwnerMem)
        r_ifRdata <= BASE_RDATA;
      else if (w_extDone & w_extDoneRead & ~w_extOwnerMem)
        r_ifRdata <= EXT_RDATA;

      if (w_memNoneGrant)
        r_memRdata <= '0;
      else if (w_baseDone & w_baseDoneRead & w_baseOwnerMem)
        r_memRdata <= BASE_RDATA;
      else if (w_extDone & w_extDoneRead & w_extOwnerMem)
        r_memRdata <= EXT_RDATA;
    end
  end

  assign IF_VALID  = r_ifValid;
  assign MEM_VALID = r_memValid;
  assign IF_RDATA  = r_ifRdata;
  assign MEM_RDATA = r_memRdata;
  assign STALL_IF  = IF_REQ & ~r_ifValid;
  assign STALL_MEM = MEM_REQ & ~r_memValid;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//   Directed bench for sram_arbiter. Requests are issued from the main flow,
//   expected completions are queued, and a monitor pops and compares on every
//   IF_VALID / MEM_VALID. Pin activity is tallied per bank so strobe timing
//   and framing can be compared against hand-computed counts.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              IF_REQ = 1'b0;
  logic [1:0]        IF_SEL = 2'b11;
  logic [ADDR_W-1:0] IF_ADDR = '0;
  logic [DATA_W-1:0] IF_RDATA;
  logic              IF_VALID;
  logic              MEM_REQ = 1'b0;
  logic              MEM_WE = 1'b0;
  logic [3:0]        MEM_BE_N = 4'hF;
  logic [1:0]        MEM_SEL = 2'b11;
  logic [ADDR_W-1:0] MEM_ADDR = '0;
  logic [DATA_W-1:0] MEM_WDATA = '0;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_VALID;
  logic              STALL_IF, STALL_MEM;
  logic              BASE_CE_N, BASE_OE_N, BASE_WE_N, BASE_DRIVE;
  logic [3:0]        BASE_BE_N;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [DATA_W-1:0] BASE_WDATA, BASE_RDATA;
  logic              EXT_CE_N, EXT_OE_N, EXT_WE_N, EXT_DRIVE;
  logic [3:0]        EXT_BE_N;
  logic [ADDR_W-1:0] EXT_ADDR;
  logic [DATA_W-1:0] EXT_WDATA, EXT_RDATA;

  int vecCount = 0;
  int missCount = 0;
  int cyc = 0;
  int issueCyc = 0;
  int ifLat = -1;
  int memLat = -1;
  int memValidCnt = 0;

  int baseCeLow = 0, baseOeLow = 0, baseWeLow = 0, baseDrv = 0;
  int extCeLow = 0, extOeLow = 0, extWeLow = 0, extDrv = 0;
  int sBaseCe, sBaseOe, sBaseWe, sBaseDrv, sExtCe, sExtOe, sExtWe, sExtDrv;
  logic [7:0]        extWeHist = 8'hFF;
  logic [DATA_W-1:0] extWdSeen = '0;
  logic [3:0]        extBeSeen = 4'hF;
  logic [ADDR_W-1:0] extAddrSeen = '0;
  logic [ADDR_W-1:0] baseRdAddrSeen = '0;

  exp_t ifQ[$];
  exp_t memQ[$];

  sram_arbiter dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_SEL(IF_SEL), .IF_ADDR(IF_ADDR),
    .IF_RDATA(IF_RDATA), .IF_VALID(IF_VALID),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BE_N(MEM_BE_N), .MEM_SEL(MEM_SEL),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_VALID(MEM_VALID),
    .STALL_IF(STALL_IF), .STALL_MEM(STALL_MEM),
    .BASE_CE_N(BASE_CE_N), .BASE_OE_N(BASE_OE_N), .BASE_WE_N(BASE_WE_N),
    .BASE_BE_N(BASE_BE_N), .BASE_ADDR(BASE_ADDR), .BASE_WDATA(BASE_WDATA),
    .BASE_DRIVE(BASE_DRIVE), .BASE_RDATA(BASE_RDATA),
    .EXT_CE_N(EXT_CE_N), .EXT_OE_N(EXT_OE_N), .EXT_WE_N(EXT_WE_N),
    .EXT_BE_N(EXT_BE_N), .EXT_ADDR(EXT_ADDR), .EXT_WDATA(EXT_WDATA),
    .EXT_DRIVE(EXT_DRIVE), .EXT_RDATA(EXT_RDATA)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM read-data model: one fixed word at BASE 0x00010, otherwise a tag
  // plus the address so every read returns a distinct, predictable word.
  always_comb begin
    BASE_RDATA = (BASE_ADDR == 20'h00010) ? 32'hDEADBEEF : {12'hBA5, BASE_ADDR};
    EXT_RDATA  = {12'hE77, EXT_ADDR};
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor plus pin tallies, all sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (IF_VALID === 1'b1) begin
        if (ifQ.size() == 0) checkOutput("if_unexpected_valid", {31'd0, IF_VALID}, 32'd0);
        else begin
          e = ifQ.pop_front();
          if (e.chk) checkOutput("if_rdata", IF_RDATA, e.data);
        end
      end
      if (MEM_VALID === 1'b1) begin
        memValidCnt++;
        if (memQ.size() == 0) checkOutput("mem_unexpected_valid", {31'd0, MEM_VALID}, 32'd0);
        else begin
          e = memQ.pop_front();
          if (e.chk) checkOutput("mem_rdata", MEM_RDATA, e.data);
        end
      end
      if (BASE_CE_N === 1'b0) baseCeLow++;
      if (BASE_OE_N === 1'b0) begin
        baseOeLow++;
        baseRdAddrSeen = BASE_ADDR;
      end
      if (BASE_WE_N === 1'b0) baseWeLow++;
      if (BASE_DRIVE === 1'b1) baseDrv++;
      if (EXT_CE_N === 1'b0) begin
        extCeLow++;
        extWeHist = {extWeHist[6:0], EXT_WE_N};
      end
      if (EXT_OE_N === 1'b0) extOeLow++;
      if (EXT_WE_N === 1'b0) begin
        extWeLow++;
        extWdSeen   = EXT_WDATA;
        extBeSeen   = EXT_BE_N;
        extAddrSeen = EXT_ADDR;
      end
      if (EXT_DRIVE === 1'b1) extDrv++;
    end
  end

  task automatic snapshot();
    sBaseCe = baseCeLow; sBaseOe = baseOeLow; sBaseWe = baseWeLow; sBaseDrv = baseDrv;
    sExtCe  = extCeLow;  sExtOe  = extOeLow;  sExtWe  = extWeLow;  sExtDrv  = extDrv;
  endtask

  task automatic applyStimulus(input bit ifReq, input logic [1:0] ifSel,
                               input logic [19:0] ifAddr, input bit memReq,
                               input bit memWe, input logic [3:0] memBe,
                               input logic [1:0] memSel, input logic [19:0] memAddr,
                               input logic [31:0] memWdata);
    @(negedge CLK);
    #1;
    snapshot();
    IF_REQ    = ifReq;
    IF_SEL    = ifSel;
    IF_ADDR   = ifAddr;
    MEM_REQ   = memReq;
    MEM_WE    = memWe;
    MEM_BE_N  = memBe;
    MEM_SEL   = memSel;
    MEM_ADDR  = memAddr;
    MEM_WDATA = memWdata;
    issueCyc  = cyc;
    ifLat     = -1;
    memLat    = -1;
    #1;
    if (ifReq)  checkOutput("stall_if_while_waiting", {31'd0, STALL_IF}, 32'd1);
    if (memReq) checkOutput("stall_mem_while_waiting", {31'd0, STALL_MEM}, 32'd1);
  endtask

  // Holds requests until their VALID, records latency, then lets one more
  // cycle pass so the tallies and the scoreboard are settled.
  task automatic runUntilDone();
    for (int i = 0; i < 20 && (IF_REQ || MEM_REQ); i++) begin
      @(negedge CLK);
      #1;
      if (IF_REQ && IF_VALID) begin
        ifLat = cyc - issueCyc;
        checkOutput("stall_if_in_valid_cycle", {31'd0, STALL_IF}, 32'd0);
        IF_REQ = 1'b0;
      end
      if (MEM_REQ && MEM_VALID) begin
        memLat = cyc - issueCyc;
        checkOutput("stall_mem_in_valid_cycle", {31'd0, STALL_MEM}, 32'd0);
        MEM_REQ = 1'b0;
      end
    end
    if (IF_REQ || MEM_REQ) begin
      checkOutput("completion_timeout", {30'd0, IF_REQ, MEM_REQ}, 32'd0);
      IF_REQ  = 1'b0;
      MEM_REQ = 1'b0;
    end
    @(negedge CLK);
    #1;
    checkOutput("scoreboard_drained", ifQ.size() + memQ.size(), 32'd0);
  endtask

  initial begin
    int snapValid;

    // Reset values
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("rst_base_strobes", {BASE_CE_N, BASE_OE_N, BASE_WE_N, BASE_DRIVE}, 4'b1110);
    checkOutput("rst_ext_strobes", {EXT_CE_N, EXT_OE_N, EXT_WE_N, EXT_DRIVE}, 4'b1110);
    checkOutput("rst_be_n", {BASE_BE_N, EXT_BE_N}, 8'hFF);
    checkOutput("rst_addr", BASE_ADDR | EXT_ADDR, 32'd0);
    checkOutput("rst_valids", {IF_VALID, MEM_VALID}, 2'b00);
    checkOutput("rst_rdata", IF_RDATA | MEM_RDATA, 32'd0);
    RST = 1'b1;

    // IF read from BASE
    ifQ.push_back('{1'b1, 32'hDEADBEEF});
    applyStimulus(1, 2'b10, 20'h00010, 0, 0, 4'hF, 2'b11, 20'h0, 32'h0);
    runUntilDone();
    checkOutput("if_read_latency", ifLat, 32'd2);
    checkOutput("if_read_oe_cycles", baseOeLow - sBaseOe, 32'd1);
    checkOutput("if_read_addr", {12'd0, baseRdAddrSeen}, 32'h00010);
    checkOutput("if_read_no_we", baseWeLow - sBaseWe, 32'd0);

    // MEM write to EXT
    memQ.push_back('{1'b0, 32'h0});
    applyStimulus(0, 2'b11, 20'h0, 1, 1, 4'b1100, 2'b01, 20'h00400, 32'h12345678);
    runUntilDone();
    checkOutput("mem_write_latency", memLat, 32'd5);
    checkOutput("mem_write_we_cycles", extWeLow - sExtWe, 32'd2);
    checkOutput("mem_write_ce_cycles", extCeLow - sExtCe, 32'd4);
    checkOutput("mem_write_drive_cycles", extDrv - sExtDrv, 32'd4);
    checkOutput("mem_write_we_framing", {28'd0, extWeHist[3:0]}, 32'b1001);
    checkOutput("mem_write_no_oe", extOeLow - sExtOe, 32'd0);
    checkOutput("mem_write_data", extWdSeen, 32'h12345678);
    checkOutput("mem_write_be", {28'd0, extBeSeen}, 32'hC);
    checkOutput("mem_write_addr", {12'd0, extAddrSeen}, 32'h00400);
    checkOutput("mem_write_base_quiet", baseCeLow - sBaseCe, 32'd0);

    // Conflict on BASE: MEM first, IF afterwards
    memQ.push_back('{1'b1, 32'hBA500020});
    ifQ.push_back('{1'b1, 32'hBA500030});
    applyStimulus(1, 2'b00, 20'h00030, 1, 0, 4'h0, 2'b10, 20'h00020, 32'h0);
    runUntilDone();
    checkOutput("conflict_mem_latency", memLat, 32'd2);
    checkOutput("conflict_if_latency", ifLat, 32'd4);
    checkOutput("conflict_base_oe_cycles", baseOeLow - sBaseOe, 32'd2);

    // Parallel: IF on BASE, MEM read on EXT
    ifQ.push_back('{1'b1, 32'hBA500044});
    memQ.push_back('{1'b1, 32'hE7700088});
    applyStimulus(1, 2'b10, 20'h00044, 1, 0, 4'h0, 2'b01, 20'h00088, 32'h0);
    runUntilDone();
    checkOutput("parallel_if_latency", ifLat, 32'd2);
    checkOutput("parallel_mem_latency", memLat, 32'd2);
    checkOutput("parallel_ext_oe_cycles", extOeLow - sExtOe, 32'd1);

    // Unmapped select write is dropped
    memQ.push_back('{1'b1, 32'h0});
    applyStimulus(0, 2'b11, 20'h0, 1, 1, 4'h0, 2'b11, 20'h00123, 32'hCAFEF00D);
    runUntilDone();
    checkOutput("unmapped_latency", memLat, 32'd1);
    checkOutput("unmapped_ce_activity", (baseCeLow - sBaseCe) + (extCeLow - sExtCe), 32'd0);

    // Reset in the middle of a BASE write pulse
    applyStimulus(0, 2'b11, 20'h0, 1, 1, 4'h0, 2'b00, 20'h00077, 32'h55AA55AA);
    for (int i = 0; i < 10 && BASE_WE_N !== 1'b0; i++) begin
      @(negedge CLK);
      #1;
    end
    checkOutput("abort_reached_wpulse", {31'd0, BASE_WE_N}, 32'd0);
    snapValid = memValidCnt;
    RST     = 1'b0;
    MEM_REQ = 1'b0;
    #1;
    checkOutput("abort_strobes_async", {BASE_CE_N, BASE_OE_N, BASE_WE_N, BASE_DRIVE}, 4'b1110);
    checkOutput("abort_be_n", {28'd0, BASE_BE_N}, 32'hF);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    repeat (8) @(negedge CLK);
    #1;
    checkOutput("abort_no_valid", memValidCnt - snapValid, 32'd0);

    // Recovery after the abort
    memQ.push_back('{1'b1, 32'hBA500055});
    applyStimulus(0, 2'b11, 20'h0, 1, 0, 4'h0, 2'b10, 20'h00055, 32'h0);
    runUntilDone();
    checkOutput("recovery_mem_latency", memLat, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
